// File: rtl/video_pattern_gen.sv
// video_pattern_gen: run-time configurable video timing and test-pattern generator, config shadowed per frame.
// Define VPG_MOVING_BAR_EN to turn pattern 7 into a 16-px white bar that moves one pixel per frame.
module video_pattern_gen #(
    parameter int COLOR_W = 8,
    parameter int CNT_W   = 12,
    parameter int CHK_SH  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [CNT_W-1:0]   h_active,
    input  logic [CNT_W-1:0]   h_fp,
    input  logic [CNT_W-1:0]   h_sync,
    input  logic [CNT_W-1:0]   h_bp,
    input  logic [CNT_W-1:0]   v_active,
    input  logic [CNT_W-1:0]   v_fp,
    input  logic [CNT_W-1:0]   v_sync,
    input  logic [CNT_W-1:0]   v_bp,
    input  logic               hs_pol,
    input  logic               vs_pol,
    input  logic [2:0]         mode,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic [COLOR_W-1:0] rgb_r,
    output logic [COLOR_W-1:0] rgb_g,
    output logic [COLOR_W-1:0] rgb_b,
    output logic [CNT_W-1:0]   pix_x,
    output logic [CNT_W-1:0]   pix_y,
    output logic               frame_start,
    output logic               cfg_err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam int TW = CNT_W + 2;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [TW-1:0] MAXT = TW'((2 ** CNT_W) - 1);

    logic [0:0] state;
    logic [CNT_W-1:0] hcnt, vcnt, bx, bw;
    logic [3:0] bi;
    logic [CNT_W-1:0] s_ha, s_hss, s_hse, s_htl, s_va, s_vss, s_vse, s_vtl;
    logic s_hpol, s_vpol;
    logic [2:0] s_mode, c;
    logic [TW-1:0] htw, vtw;
    logic legal, h_end, f_end, bound, go, h_act, v_act, hsy, vsy, dc, bar_end, mark;

    assign htw = TW'(h_active) + TW'(h_fp) + TW'(h_sync) + TW'(h_bp);
    assign vtw = TW'(v_active) + TW'(v_fp) + TW'(v_sync) + TW'(v_bp);
    assign legal = |h_active && |v_active && |h_sync && |v_sync && htw <= MAXT && vtw <= MAXT;
    assign h_end = hcnt == s_htl;
    assign f_end = state == RUN && h_end && vcnt == s_vtl;
    assign bound = state == IDLE || f_end;
    assign go = bound && en && legal;
    assign h_act = hcnt < s_ha;
    assign v_act = vcnt < s_va;
    assign hsy = hcnt >= s_hss && hcnt < s_hse;
    assign vsy = vcnt >= s_vss && vcnt < s_vse;
    assign dc = h_act && v_act;
    assign bw = s_ha >> 3;
    assign bar_end = bx == bw - ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            {s_ha, s_hss, s_hse, s_htl, s_va, s_vss, s_vse, s_vtl} <= '0;
            {s_hpol, s_vpol, s_mode} <= '0;
        end else if (go) begin
            s_ha   <= h_active;
            s_hss  <= h_active + h_fp;
            s_hse  <= h_active + h_fp + h_sync;
            s_htl  <= htw[CNT_W-1:0] - ONE;
            s_va   <= v_active;
            s_vss  <= v_active + v_fp;
            s_vse  <= v_active + v_fp + v_sync;
            s_vtl  <= vtw[CNT_W-1:0] - ONE;
            s_hpol <= hs_pol;
            s_vpol <= vs_pol;
            s_mode <= mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cfg_err <= 1'b0;
        end else if (bound) begin
            state <= go ? RUN : IDLE;
            if (en) cfg_err <= !legal;
        end
    end

    // bx/bi track position inside the current colour bar, avoiding a divider
    always_ff @(posedge clk) begin
        if (rst || bound || h_end) begin
            hcnt <= '0;
            bx   <= '0;
            bi   <= '0;
            vcnt <= (rst || bound) ? '0 : vcnt + ONE;
        end else begin
            hcnt <= hcnt + ONE;
            bx   <= bar_end ? '0 : bx + ONE;
            bi   <= (bar_end && !bi[3]) ? bi + 4'd1 : bi;
        end
    end

`ifdef VPG_MOVING_BAR_EN
    logic [CNT_W-1:0] fcnt;
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) fcnt <= '0;
        else if (f_end) fcnt <= (fcnt + ONE >= s_ha) ? '0 : fcnt + ONE;
    end
    assign mark = hcnt >= fcnt && hcnt - fcnt < CNT_W'(16);
`else
    assign mark = hcnt[CHK_SH] ^ vcnt[CHK_SH];
`endif

    // c = {r,g,b} full-on flags; bar order falls out of inverted index bits
    always_comb begin
        c = 3'b000;
        case (s_mode)
            3'd0:    c = (bi[3] || bw == '0) ? 3'b000 : ~{bi[1], bi[2], bi[0]};
            3'd2:    c = 3'b111;
            3'd4:    c = 3'b100;
            3'd5:    c = 3'b010;
            3'd6:    c = 3'b001;
            3'd7:    c = {3{mark}};
            default: c = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            de          <= 1'b0;
            hs          <= ~hs_pol;
            vs          <= ~vs_pol;
            frame_start <= 1'b0;
            rgb_r       <= '0;
            rgb_g       <= '0;
            rgb_b       <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
        end else begin
            de          <= dc;
            hs          <= ~(hsy ^ s_hpol);
            vs          <= ~(vsy ^ s_vpol);
            frame_start <= hcnt == '0 && vcnt == '0;
            rgb_r       <= !dc ? '0 : s_mode == 3'd1 ? hcnt[COLOR_W-1:0] : {COLOR_W{c[2]}};
            rgb_g       <= !dc ? '0 : s_mode == 3'd1 ? hcnt[COLOR_W-1:0] : {COLOR_W{c[1]}};
            rgb_b       <= !dc ? '0 : s_mode == 3'd1 ? hcnt[COLOR_W-1:0] : {COLOR_W{c[0]}};
            pix_x       <= dc ? hcnt : '0;
            pix_y       <= dc ? vcnt : '0;
        end
    end
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: pixel-probe vector table plus frame-level sequences for video_pattern_gen.
module tb_video_pattern_gen;
    typedef struct {
        logic [2:0] mode;
        int         x;
        int         y;
        logic       dex;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vec_t;
    typedef struct {
        int len;
        int de_n;
        int hs_n;
        int hs_hi;
        int hs_lo;
        int vs_n;
        int vs_first;
        int white_n;
        int red_n;
        int bad;
    } fr_t;

`ifdef VPG_MOVING_BAR_EN
    localparam int NV = 17;
`else
    localparam int NV = 18;
`endif

    logic clk = 1'b0, rst = 1'b1, en = 1'b1;
    logic [11:0] h_active = 12'd16, h_fp = 12'd2, h_sync = 12'd3, h_bp = 12'd4;
    logic [11:0] v_active = 12'd8, v_fp = 12'd1, v_sync = 12'd2, v_bp = 12'd3;
    logic hs_pol = 1'b1, vs_pol = 1'b1;
    logic [2:0] mode = 3'd2;
    logic hs, vs, de, frame_start, cfg_err;
    logic [7:0] rgb_r, rgb_g, rgb_b;
    logic [11:0] pix_x, pix_y;
    int tests = 0, fails = 0;
    vec_t vt[NV];
    fr_t f;

    always #5 clk = ~clk;

    video_pattern_gen dut (
        .clk(clk), .rst(rst), .en(en),
        .h_active(h_active), .h_fp(h_fp), .h_sync(h_sync), .h_bp(h_bp),
        .v_active(v_active), .v_fp(v_fp), .v_sync(v_sync), .v_bp(v_bp),
        .hs_pol(hs_pol), .vs_pol(vs_pol), .mode(mode),
        .hs(hs), .vs(vs), .de(de),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .cfg_err(cfg_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 1000);
        if (!frame_start) chk("wait_fs_timeout", 64'(frame_start), 64'd1);
    endtask

    // call on a frame_start sample; returns on the next frame_start sample
    task automatic run_frame(input int chg_k, input logic [11:0] nha, input logic [2:0] nmode, output fr_t r);
        int k;
        r.len = -1; r.de_n = 0; r.hs_n = 0; r.hs_hi = -1; r.hs_lo = -1;
        r.vs_n = 0; r.vs_first = -1; r.white_n = 0; r.red_n = 0; r.bad = 0;
        k = 0;
        do begin
            if (k == chg_k) begin
                h_active = nha;
                mode = nmode;
            end
            if (de) r.de_n++;
            else if ({rgb_r, rgb_g, rgb_b, pix_x, pix_y} != '0) r.bad++;
            if (de && {rgb_r, rgb_g, rgb_b} == 24'hFFFFFF) r.white_n++;
            if (de && {rgb_r, rgb_g, rgb_b} == 24'hFF0000) r.red_n++;
            if (hs) begin
                r.hs_n++;
                if (r.hs_hi < 0) r.hs_hi = k;
            end else if (r.hs_lo < 0) r.hs_lo = k;
            if (vs) begin
                r.vs_n++;
                if (r.vs_first < 0) r.vs_first = k;
            end
            tick();
            k++;
        end while (!frame_start && k < 5000);
        r.len = frame_start ? k : -1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{3'd0, 0, 0, 1'b1, 8'hFF, 8'hFF, 8'hFF};
        vt[1]  = '{3'd0, 3, 1, 1'b1, 8'hFF, 8'hFF, 8'h00};
        vt[2]  = '{3'd0, 5, 2, 1'b1, 8'h00, 8'hFF, 8'hFF};
        vt[3]  = '{3'd0, 6, 2, 1'b1, 8'h00, 8'hFF, 8'h00};
        vt[4]  = '{3'd0, 9, 0, 1'b1, 8'hFF, 8'h00, 8'hFF};
        vt[5]  = '{3'd0, 11, 5, 1'b1, 8'hFF, 8'h00, 8'h00};
        vt[6]  = '{3'd0, 13, 7, 1'b1, 8'h00, 8'h00, 8'hFF};
        vt[7]  = '{3'd0, 15, 7, 1'b1, 8'h00, 8'h00, 8'h00};
        vt[8]  = '{3'd1, 7, 3, 1'b1, 8'h07, 8'h07, 8'h07};
        vt[9]  = '{3'd1, 15, 0, 1'b1, 8'h0F, 8'h0F, 8'h0F};
        vt[10] = '{3'd2, 16, 0, 1'b0, 8'h00, 8'h00, 8'h00};
        vt[11] = '{3'd2, 0, 8, 1'b0, 8'h00, 8'h00, 8'h00};
        vt[12] = '{3'd2, 10, 5, 1'b1, 8'hFF, 8'hFF, 8'hFF};
        vt[13] = '{3'd3, 4, 4, 1'b1, 8'h00, 8'h00, 8'h00};
        vt[14] = '{3'd4, 1, 1, 1'b1, 8'hFF, 8'h00, 8'h00};
        vt[15] = '{3'd5, 2, 2, 1'b1, 8'h00, 8'hFF, 8'h00};
        vt[16] = '{3'd6, 3, 3, 1'b1, 8'h00, 8'h00, 8'hFF};
`ifndef VPG_MOVING_BAR_EN
        vt[17] = '{3'd7, 0, 0, 1'b1, 8'h00, 8'h00, 8'h00};
`endif

        repeat (3) tick();
        chk("reset_state", 64'({de, hs, vs, frame_start, cfg_err, rgb_r, rgb_g, rgb_b, pix_x, pix_y}), 64'd0);
        rst = 1'b0;
        tick();
        chk("fs_not_yet", 64'(frame_start), 64'd0);
        tick();
        chk("fs_first", 64'(frame_start), 64'd1);

        run_frame(-1, 12'd16, 3'd2, f);
        chk("frame_len", 64'(f.len), 64'd350);
        chk("de_count", 64'(f.de_n), 64'd128);
        chk("hs_count", 64'(f.hs_n), 64'd42);
        chk("hs_first", 64'(f.hs_hi), 64'd18);
        chk("vs_count", 64'(f.vs_n), 64'd50);
        chk("vs_first", 64'(f.vs_first), 64'd225);
        chk("white_px", 64'(f.white_n), 64'd128);
        chk("blank_zero", 64'(f.bad), 64'd0);

        for (int i = 0; i < NV; i++) begin
            mode = vt[i].mode;
            wait_fs();
            repeat (vt[i].y * 25 + vt[i].x) tick();
            chk($sformatf("vec%0d_m%0d_x%0d_y%0d", i, vt[i].mode, vt[i].x, vt[i].y),
                64'({de, rgb_r, rgb_g, rgb_b, pix_x, pix_y}),
                64'({vt[i].dex, vt[i].r, vt[i].g, vt[i].b,
                     vt[i].dex ? 12'(vt[i].x) : 12'd0, vt[i].dex ? 12'(vt[i].y) : 12'd0}));
        end

        mode = 3'd2;
        wait_fs();
        run_frame(100, 12'd20, 3'd4, f);
        chk("chg_len_same", 64'(f.len), 64'd350);
        chk("chg_de_same", 64'(f.de_n), 64'd128);
        chk("chg_white_same", 64'(f.white_n), 64'd128);
        run_frame(10, 12'd16, 3'd2, f);
        chk("new_len", 64'(f.len), 64'd406);
        chk("new_de", 64'(f.de_n), 64'd160);
        chk("new_red", 64'(f.red_n), 64'd160);
        chk("new_hs_first", 64'(f.hs_hi), 64'd22);
        chk("new_vs_first", 64'(f.vs_first), 64'd261);

        begin
            int n, seen;
            v_sync = 12'd0;
            n = 0;
            while (!cfg_err && n < 1000) begin
                tick();
                n++;
            end
            chk("cfg_err_at_end", 64'(n), 64'd349);
            seen = 0;
            repeat (20) begin
                tick();
                if (frame_start || de) seen++;
            end
            chk("idle_quiet", 64'(seen), 64'd0);
            chk("cfg_err_sticky", 64'(cfg_err), 64'd1);
            v_sync = 12'd2;
            tick();
            chk("cfg_err_clear", 64'({cfg_err, frame_start}), 64'd0);
            tick();
            chk("resume_fs", 64'(frame_start), 64'd1);
        end

        hs_pol = 1'b0;
        run_frame(-1, 12'd16, 3'd2, f);
        chk("pol_shadowed", 64'(f.hs_n), 64'd42);
        run_frame(-1, 12'd16, 3'd2, f);
        chk("neg_hs_high", 64'(f.hs_n), 64'd308);
        chk("neg_hs_low_at", 64'(f.hs_lo), 64'd18);
        chk("neg_hs_idle", 64'(f.hs_hi), 64'd0);
        repeat (105) tick();
        chk("pre_rst_pos", 64'({de, pix_x, pix_y}), 64'({1'b1, 12'd5, 12'd4}));
        rst = 1'b1;
        tick();
        chk("mid_rst", 64'({de, hs, vs, frame_start, rgb_r, rgb_g, rgb_b, pix_x, pix_y}),
            64'({1'b0, 1'b1, 1'b0, 1'b0, 48'd0}));
        hs_pol = 1'b1;
        rst = 1'b0;
        tick();
        chk("rst_fs_not_yet", 64'(frame_start), 64'd0);
        tick();
        chk("rst_fs", 64'(frame_start), 64'd1);

`ifdef VPG_MOVING_BAR_EN
        mode = 3'd7;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("mb_fs", 64'(frame_start), 64'd1);
        for (int fr = 0; fr <= 16; fr++) begin
            logic [23:0] p2, p3;
            tick();
            tick();
            p2 = {rgb_r, rgb_g, rgb_b};
            tick();
            p3 = {rgb_r, rgb_g, rgb_b};
            if (fr == 0) chk("mb_f0", 64'({p2, p3}), 64'({24'hFFFFFF, 24'hFFFFFF}));
            if (fr == 3) chk("mb_f3", 64'({p2, p3}), 64'({24'h000000, 24'hFFFFFF}));
            if (fr == 15) chk("mb_f15", 64'(p2), 64'h000000);
            if (fr == 16) chk("mb_f16_wrap", 64'({p2, p3}), 64'({24'hFFFFFF, 24'hFFFFFF}));
            wait_fs();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
